// File: rtl/locked_register_bank_if.sv
// Config-bus bundle for locked_register_bank: write/lock/read strobes, scan and
// debug-unlock controls, and the read data and status outputs.
interface locked_register_bank_if #(
    parameter int NUM_REGS   = 4,
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = $clog2(NUM_REGS),
    parameter int KEY_WIDTH  = 32
);
    logic                  write;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] Data_in;
    logic                  lock;
    logic [ADDR_WIDTH-1:0] lock_addr;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  scan_mode;
    logic                  dbg_unlock_req;
    logic [KEY_WIDTH-1:0]  dbg_key;
    logic                  dbg_exit;
    logic [DATA_WIDTH-1:0] Data_out;
    logic [NUM_REGS-1:0]   lock_status;
    logic                  debug_unlocked;
    logic                  dbg_lockout;
    logic                  write_error;

    modport master (
        output write, wr_addr, Data_in, lock, lock_addr, rd_addr, scan_mode,
               dbg_unlock_req, dbg_key, dbg_exit,
        input  Data_out, lock_status, debug_unlocked, dbg_lockout, write_error
    );

    modport slave (
        input  write, wr_addr, Data_in, lock, lock_addr, rd_addr, scan_mode,
               dbg_unlock_req, dbg_key, dbg_exit,
        output Data_out, lock_status, debug_unlocked, dbg_lockout, write_error
    );
endinterface

// File: rtl/locked_register_bank.sv
// Bank of write-lockable config registers with scan-entry clearing.
// Define LOCKED_REG_DEBUG_UNLOCK_EN to build the key-authenticated debug unlock FSM.
module locked_register_bank #(
    parameter int                   NUM_REGS     = 4,
    parameter int                   DATA_WIDTH   = 16,
    parameter int                   ADDR_WIDTH   = $clog2(NUM_REGS),
    parameter int                   KEY_WIDTH    = 32,
    parameter logic [KEY_WIDTH-1:0] DEBUG_KEY    = 32'hA5C3_0F1E,
    parameter int                   MAX_ATTEMPTS = 3
) (
    input logic                   Clk,
    input logic                   reset,
    locked_register_bank_if.slave bus
);
    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
    logic [NUM_REGS-1:0]   lock_status_q, lock_status_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  write_error_q, write_error_d;
    logic                  scan_q, scan_d;

    logic wr_ok, lock_ok, rd_ok;
    logic scan_entry, wr_accept, dbg_unlocked;

    // Address range checks collapse to constants when the address space is fully populated.
    if (NUM_REGS == (1 << ADDR_WIDTH)) begin : g_full_map
        assign wr_ok   = 1'b1;
        assign lock_ok = 1'b1;
        assign rd_ok   = 1'b1;
    end else begin : g_part_map
        assign wr_ok   = (int'(bus.wr_addr) < NUM_REGS);
        assign lock_ok = (int'(bus.lock_addr) < NUM_REGS);
        assign rd_ok   = (int'(bus.rd_addr) < NUM_REGS);
    end

`ifdef LOCKED_REG_DEBUG_UNLOCK_EN
    typedef enum logic [1:0] {
        DBG_LOCKED   = 2'd0,
        DBG_CHECK    = 2'd1,
        DBG_UNLOCKED = 2'd2,
        DBG_LOCKOUT  = 2'd3
    } dbg_state_e;

    dbg_state_e           state_q, state_d;
    logic [3:0]           fail_cnt_q, fail_cnt_d;
    logic [KEY_WIDTH-1:0] key_q, key_d;
    logic [3:0]           fail_next;

    assign fail_next = fail_cnt_q + 4'd1;

    always_comb begin
        state_d    = state_q;
        fail_cnt_d = fail_cnt_q;
        key_d      = key_q;
        unique case (state_q)
            DBG_LOCKED: begin
                if (bus.dbg_unlock_req && !bus.scan_mode) begin
                    key_d   = bus.dbg_key;
                    state_d = DBG_CHECK;
                end
            end
            // Key is compared from its register, never straight from the port.
            DBG_CHECK: begin
                if (key_q == DEBUG_KEY) begin
                    fail_cnt_d = 4'd0;
                    state_d    = DBG_UNLOCKED;
                end else begin
                    fail_cnt_d = fail_next;
                    state_d    = (fail_next == 4'(MAX_ATTEMPTS)) ? DBG_LOCKOUT : DBG_LOCKED;
                end
            end
            DBG_UNLOCKED: begin
                if (bus.dbg_exit || bus.scan_mode) state_d = DBG_LOCKED;
            end
            DBG_LOCKOUT: state_d = DBG_LOCKOUT;
            default:     state_d = DBG_LOCKED;
        endcase
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            state_q    <= DBG_LOCKED;
            fail_cnt_q <= 4'd0;
            key_q      <= '0;
        end else begin
            state_q    <= state_d;
            fail_cnt_q <= fail_cnt_d;
            key_q      <= key_d;
        end
    end

    assign dbg_unlocked       = (state_q == DBG_UNLOCKED);
    assign bus.dbg_lockout    = (state_q == DBG_LOCKOUT);
`else
    logic unused_dbg;
    assign unused_dbg = ^{bus.dbg_unlock_req, bus.dbg_key, bus.dbg_exit,
                          DEBUG_KEY, 4'(MAX_ATTEMPTS)};

    assign dbg_unlocked    = 1'b0;
    assign bus.dbg_lockout = 1'b0;
`endif

    // Write is judged against the pre-edge lock bit, so a same-cycle lock still lets it land.
    always_comb begin
        scan_entry = bus.scan_mode && !scan_q;
        wr_accept  = bus.write && wr_ok && !bus.scan_mode &&
                     (!lock_status_q[bus.wr_addr] || dbg_unlocked);

        regs_d = regs_q;
        if (scan_entry) begin
            for (int i = 0; i < NUM_REGS; i++) regs_d[i] = '0;
        end else if (wr_accept) begin
            regs_d[bus.wr_addr] = bus.Data_in;
        end

        lock_status_d = lock_status_q;
        if (bus.lock && lock_ok) lock_status_d[bus.lock_addr] = 1'b1;

        write_error_d = bus.write && !wr_accept;
        data_out_d    = rd_ok ? regs_q[bus.rd_addr] : '0;
        scan_d        = bus.scan_mode;
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            regs_q        <= '{default: '0};
            lock_status_q <= '0;
            data_out_q    <= '0;
            write_error_q <= 1'b0;
            scan_q        <= 1'b0;
        end else begin
            regs_q        <= regs_d;
            lock_status_q <= lock_status_d;
            data_out_q    <= data_out_d;
            write_error_q <= write_error_d;
            scan_q        <= scan_d;
        end
    end

    assign bus.Data_out       = data_out_q;
    assign bus.lock_status    = lock_status_q;
    assign bus.write_error    = write_error_q;
    assign bus.debug_unlocked = dbg_unlocked;
endmodule

// File: doc/locked_register_bank.md
Name: locked_register_bank

Overview:
Parametrised bank of NUM_REGS write-lockable configuration registers. Successor to the single lockable register.
- Per-register sticky lock bits.
- Scan mode no longer bypasses locks; entering scan clears all contents.
- Debug override requires a key-authenticated unlock FSM with attempt lockout.
- Sits between the config bus and security-sensitive IP.

Parameters:
NUM_REGS, 4, number of registers (2..32)
DATA_WIDTH, 16, register width
ADDR_WIDTH, $clog2(NUM_REGS), address width
KEY_WIDTH, 32, debug key width
DEBUG_KEY, 32'hA5C3_0F1E, expected unlock key
MAX_ATTEMPTS, 3, failed unlocks before permanent lockout (1..15)

Ports:
Clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high; clears all state
write  in  1  write strobe
wr_addr  in  ADDR_WIDTH  write target
Data_in  in  DATA_WIDTH  write data
lock  in  1  lock strobe
lock_addr  in  ADDR_WIDTH  register to lock
rd_addr  in  ADDR_WIDTH  read select
scan_mode  in  1  scan/test mode active
dbg_unlock_req  in  1  unlock attempt strobe
dbg_key  in  KEY_WIDTH  key sampled with dbg_unlock_req
dbg_exit  in  1  leave unlocked state
Data_out  out  DATA_WIDTH  registered read data
lock_status  out  NUM_REGS  per-register lock bits
debug_unlocked  out  1  high in DBG_UNLOCKED
dbg_lockout  out  1  high in DBG_LOCKOUT
write_error  out  1  one-cycle pulse on rejected write

Behaviour:
- Reset: all registers 0, lock_status 0, Data_out 0, write_error 0. FSM to DBG_LOCKED with fail_cnt 0; scan_q 0. Reset mid-operation aborts everything, including lockout.
- Lock: lock=1 sets lock_status[lock_addr] next edge. Sticky; only reset clears it. lock_addr >= NUM_REGS is ignored.
- Write accepted when write=1, wr_addr < NUM_REGS, scan_mode=0, and (lock_status[wr_addr]=0 or debug_unlocked=1). Register updates next edge.
- Rejected write (any condition false): register unchanged; write_error=1 for the following cycle.
- Same-cycle write and lock to the same register: write is judged against the pre-edge lock bit, so it lands and the lock is set.
- Scan: scan_q registers scan_mode. The cycle scan_mode=1 with scan_q=0 (entry edge) clears all data registers. Lock bits are kept. A concurrent write is rejected. No writes while scan_mode=1. Leaving scan has no side effect.
- Read: Data_out <= reg[rd_addr] every edge (1-cycle latency); 0 if rd_addr >= NUM_REGS. Same-edge write and read of the same address returns the old value.
- Debug FSM states:
  - DBG_LOCKED: dbg_unlock_req=1 and scan_mode=0 registers dbg_key, -> DBG_CHECK.
  - DBG_CHECK, 1 cycle:
    - key==DEBUG_KEY -> DBG_UNLOCKED, fail_cnt cleared.
    - Otherwise fail_cnt+1; -> DBG_LOCKOUT if the new count == MAX_ATTEMPTS, else DBG_LOCKED.
  - DBG_UNLOCKED: dbg_exit=1 or scan_mode=1 -> DBG_LOCKED.
  - DBG_LOCKOUT: terminal until reset.
  - dbg_unlock_req is ignored outside DBG_LOCKED.
- debug_unlocked and dbg_lockout decode directly from the state register, with no extra latency.
- The unlock path is never combinational from dbg_key to write enable: minimum 2 cycles from request to first override write.

Optional Feature:
Macro LOCKED_REG_DEBUG_UNLOCK_EN.
- Defined: debug FSM and dbg_* ports as above.
- Undefined:
  - FSM and fail counter are removed.
  - debug_unlocked and dbg_lockout are tied 0; dbg_* inputs are ignored.
  - Locked registers are unwritable until reset.
  - Port list is unchanged.

Test Plan:
- Write 16'h1234 to reg 2, then lock reg 2, then write 16'hFFFF to reg 2 -> read 16'h1234, lock_status=4'b0100, write_error pulses once.
- Same-cycle write 16'hBEEF and lock on reg 1 -> reg 1 = 16'hBEEF, lock_status[1]=1; the next write to reg 1 is rejected.
- Regs hold nonzero values; scan_mode 0->1 -> all reads return 0, lock bits unchanged. Write during scan -> write_error, reg stays 0.
- Unlock with 32'hA5C3_0F1E -> debug_unlocked=1 two edges later. Write 16'h00AA to locked reg 2 succeeds. dbg_exit -> debug_unlocked=0, next write rejected.
- Three wrong keys -> dbg_lockout=1. The correct key is then ignored. Reset -> dbg_lockout=0, lock_status=0.
- Assert reset while in DBG_CHECK with writes pending -> all outputs 0 asynchronously, FSM in DBG_LOCKED after release.
